// File: rtl/picture_uart_sender.sv
// picture_uart_sender: dumps every stored pixel over UART 8N1
// as three MSB-aligned colour bytes, R then G then B.
module picture_uart_sender #(
  parameter int PIXELS     = 276185,
  parameter int BAUD_DIV   = 868,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [18:0] r_address,
  input  logic [17:0] r_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [18:0]   LAST_PIX  = 19'(PIXELS - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LATENCY - 1);

  // NEXT is folded into the last stop-bit cycle of SEND.
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND
  } state_e;

  state_e      state_q, state_d;
  logic [18:0] pix_q, pix_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] shr_q, shr_d;
  logic        done_q, done_d;
  logic        tx_q, tx_d;
  logic        busy_q;
  logic [7:0]  cur_d;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    lat_d   = lat_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shr_d   = shr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pix_d   = '0;
          lat_d   = '0;
        end
      end
      FETCH: begin
        if (lat_q == LAT_LAST) begin
          state_d = LOAD;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      LOAD: begin
        // byte0 sits in the low bits so bytes leave in R, G, B order
        shr_d   = {r_data[5:0], 2'b00,
                   r_data[11:6], 2'b00,
                   r_data[17:12], 2'b00};
        byte_d  = '0;
        bit_d   = '0;
        baud_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (baud_q != BAUD_LAST) begin
          baud_d = baud_q + 1'b1;
        end else begin
          baud_d = '0;
          if (bit_q != 4'd9) begin
            bit_d = bit_q + 1'b1;
          end else begin
            bit_d = '0;
            shr_d = {8'h00, shr_q[23:8]};
            if (byte_q != 2'd2) begin
              byte_d = byte_q + 1'b1;
            end else if (pix_q == LAST_PIX) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              pix_d   = pix_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from next-state so the line is glitch-free
  always_comb begin
    cur_d = shr_d[7:0];
    tx_d  = 1'b1;
    if (state_d == SEND) begin
      if (bit_d == 4'd0) begin
        tx_d = 1'b0;
      end else if (bit_d <= 4'd8) begin
        tx_d = cur_d[3'(bit_d - 4'd1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      lat_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shr_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      lat_q   <= lat_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shr_q   <= shr_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign r_address = pix_q;
  assign uart_tx   = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_picture_uart_sender.sv
// tb_picture_uart_sender: randomized dumps checked by a UART
// decoder against a scoreboard of expected bytes and start cycles.
module tb_picture_uart_sender;

  localparam int P   = 4;
  localparam int B   = 4;
  localparam int RD  = 2;
  localparam int PER = RD + 1 + 30 * B;
  localparam int END = P * PER + 1;

  localparam int B2   = 2;
  localparam int RD2  = 1;
  localparam int END2 = 1 * (RD2 + 1 + 30 * B2) + 1;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [18:0] r_address;
  logic [17:0] r_data;
  logic        uart_tx, busy, done;

  logic        reset2, start2;
  logic [18:0] addr2;
  logic [17:0] rdata2;
  logic        tx2, busy2, done2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   armed = 0;
  bit   flush = 0;
  bit   rnd_mode = 0;
  exp_t sb[$];

  logic [17:0] mem [0:P-1];
  logic [17:0] d1, d2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  picture_uart_sender #(
    .PIXELS(P), .BAUD_DIV(B), .RD_LATENCY(RD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .r_address(r_address), .r_data(r_data),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  picture_uart_sender #(
    .PIXELS(1), .BAUD_DIV(B2), .RD_LATENCY(RD2)
  ) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .r_address(addr2), .r_data(rdata2),
    .uart_tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc - t0);
    end
  endtask

  function automatic logic [7:0] byte_of(logic [17:0] px,
                                         int j);
    int v;
    v = (int'(px) >> (12 - 6 * j)) & 63;
    return 8'(v * 4);
  endfunction

  // BRAM with two cycles of read latency; random mode keeps
  // the true pixel only in the cycle the sender must load it.
  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (rnd_mode) begin
      r_data = 18'($urandom);
      for (int p = 0; p < P; p++)
        if (rel == p * PER + RD + 1) r_data = mem[p];
    end else begin
      r_data = d2;
    end
    d2 = d1;
    d1 = mem[r_address[1:0]];
  end

  initial begin : uart_mon
    exp_t e;
    int rel, dcnt, dstart, k;
    bit dbusy;
    logic [7:0] dbyte;
    dbusy = 0;
    dcnt = 0;
    dstart = 0;
    dbyte = '0;
    forever begin
      @(posedge clk);
      #1;
      rel = cyc - t0;
      if (flush) begin
        dbusy = 0;
        flush = 0;
      end else if (!dbusy) begin
        if (uart_tx === 1'b0) begin
          dbusy = 1;
          dcnt = 0;
          dstart = rel;
        end
      end else begin
        dcnt++;
      end
      if (dbusy && (dcnt % B) == B / 2) begin
        k = dcnt / B;
        if (k == 0) begin
          chk("start_bit", uart_tx, 0);
        end else if (k <= 8) begin
          dbyte[3'(k - 1)] = uart_tx;
        end else begin
          chk("stop_bit", uart_tx, 1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h want none", dbyte);
          end else begin
            e = sb.pop_front();
            chk("byte", dbyte, e.data);
            chk("start_cycle", dstart, e.at);
          end
          dbusy = 0;
        end
      end
    end
  end

  initial begin : ctrl_mon
    int rel;
    forever begin
      @(posedge clk);
      #1;
      rel = cyc - t0;
      if (armed) begin
        chk("busy", busy, (rel >= 1 && rel < END));
        chk("done", done, rel == END);
        if (rel >= END) begin
          chk("sb_drained", sb.size(), 0);
          armed = 0;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_tx", uart_tx, 1);
      end
    end
  end

  task automatic issue_dump();
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    armed = 1;
    start = 1;
    for (int p = 0; p < P; p++)
      for (int j = 0; j < 3; j++) begin
        e.data = byte_of(mem[p], j);
        e.at   = p * PER + RD + 2 + j * 10 * B;
        sb.push_back(e);
      end
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(int maxc);
    int n;
    n = 0;
    while (armed && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (armed) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy want done within %0d",
               maxc);
      armed = 0;
      sb.delete();
    end
  endtask

  task automatic goto_rel(int r);
    while (cyc - t0 < r) @(negedge clk);
  endtask

  task automatic pulse_at(int r);
    goto_rel(r);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic dump_small();
    logic       txh [0:END2+8];
    logic       dnh [0:END2+8];
    logic       bzh [0:END2+8];
    logic [7:0] got;
    int s, nd, dat, t2;
    @(negedge clk);
    t2 = cyc;
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    for (int r = 1; r <= END2 + 8; r++) begin
      txh[r] = tx2;
      dnh[r] = done2;
      bzh[r] = busy2;
      @(negedge clk);
    end
    chk("s2_gap", {31'd0, txh[1] & txh[RD2 + 1]}, 1);
    for (int j = 0; j < 3; j++) begin
      s = RD2 + 2 + 10 * B2 * j;
      chk("s2_start", {31'd0, txh[s] | txh[s + 1]}, 0);
      for (int k = 0; k < 8; k++) got[k] = txh[s + B2 * (k + 1)];
      chk("s2_byte", got, byte_of(rdata2, j));
      chk("s2_stop", txh[s + 9 * B2], 1);
    end
    nd = 0;
    dat = 0;
    for (int r = 1; r <= END2 + 8; r++)
      if (dnh[r] === 1'b1) begin
        nd++;
        dat = r;
      end
    chk("s2_done_at", dat, END2);
    chk("s2_done_cnt", nd, 1);
    chk("s2_busy_last", bzh[END2 - 1], 1);
    chk("s2_busy_off", bzh[END2], 0);
    chk("s2_addr", addr2, 0);
    chk("s2_tx_after", txh[END2 + 1], 1);
    if (cyc - t2 > END2 + 20) $display("note: slow small dump");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    start = 0;
    reset2 = 1;
    start2 = 0;
    rdata2 = 18'h3FFFF;
    d1 = '0;
    d2 = '0;
    mem[0] = 18'h3F000;
    mem[1] = 18'h00FC0;
    mem[2] = 18'h0003F;
    mem[3] = 18'h15A96;
    repeat (3) @(negedge clk);
    chk("rst_addr", r_address, 0);
    chk("rst_tx", uart_tx, 1);
    reset = 0;
    reset2 = 0;
    repeat (3) @(negedge clk);

    issue_dump();
    wait_idle(END + 20);

    issue_dump();
    pulse_at(50);
    pulse_at(200);
    wait_idle(END + 20);
    issue_dump();
    wait_idle(END + 20);

    issue_dump();
    goto_rel(100);
    reset = 1;
    armed = 0;
    flush = 1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("abort_tx", uart_tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_addr", r_address, 0);
    @(negedge clk);
    reset = 0;
    repeat (END + 10) @(negedge clk);
    issue_dump();
    wait_idle(END + 20);

    @(negedge clk);
    reset = 1;
    start = 1;
    @(negedge clk);
    reset = 0;
    start = 0;
    @(negedge clk);
    chk("rst_wins_busy", busy, 0);

    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < P; p++) mem[p] = 18'($urandom);
      issue_dump();
      wait_idle(END + 20);
    end

    for (int p = 0; p < P; p++) mem[p] = 18'($urandom);
    rnd_mode = 1;
    issue_dump();
    wait_idle(END + 20);
    rnd_mode = 0;

    dump_small();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
